kid_motion: RTL and testbench

KID_MOTION -- requirements
Module: kid_motion

---
 rtl/kid_pkg.sv | 21 ++
 rtl/kid_motion_if.sv | 28 ++
 rtl/kid_vert_step.sv | 59 +++++
 rtl/kid_motion.sv | 196 +++++++++++++++++++
 tb/tb_kid_motion.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/kid_pkg.sv
// rtl/kid_pkg.sv - shared state encoding, key indices and velocity type for kid_motion
package kid_pkg;

    // Vertical velocity: two's complement, positive = up.
    localparam int VY_W = 6;
    typedef logic signed [VY_W-1:0] vy_t;

    typedef enum logic [2:0] {
        ST_GROUND = 3'd0,
        ST_JUMP   = 3'd1,
        ST_FALL   = 3'd2,
        ST_DEAD   = 3'd3
    } kid_state_t;

    // Bit positions inside keys[3:0].
    localparam int KEY_LEFT    = 0;
    localparam int KEY_RIGHT   = 1;
    localparam int KEY_JUMP    = 2;
    localparam int KEY_RESTART = 3;

endpackage

// File: rtl/kid_motion_if.sv
// rtl/kid_motion_if.sv - control inputs and sprite state outputs of kid_motion
// master: drives update_en/keys/hit and observes the sprite state.
// slave : the motion engine; consumes the controls, drives kid_x/kid_y/facing/
//         kid_state/jumps_used/alive.
interface kid_motion_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           update_en;
    logic [3:0]     keys;
    logic           hit;
    logic [X_W-1:0] kid_x;
    logic [Y_W-1:0] kid_y;
    logic           facing;
    logic [2:0]     kid_state;
    logic [1:0]     jumps_used;
    logic           alive;

    modport master (
        output update_en, keys, hit,
        input  kid_x, kid_y, facing, kid_state, jumps_used, alive
    );

    modport slave (
        input  update_en, keys, hit,
        output kid_x, kid_y, facing, kid_state, jumps_used, alive
    );
endinterface

// File: rtl/kid_vert_step.sv
// rtl/kid_vert_step.sv - one physics tick of vertical motion with floor/ceiling resolve
// Purely combinational.
// Ports: y/vy      current top edge and velocity (positive = up)
//        y_next    resolved top edge after the tick
//        vy_next   velocity after gravity and terminal-speed limit
//        landed    the tick reached or passed the floor line
//        bumped    the tick went above the top of the playfield
module kid_vert_step
    import kid_pkg::*;
#(
    parameter int Y_W      = 10,
    parameter int FLOOR_Y  = 464,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 9
) (
    input  logic [Y_W-1:0] y,
    input  vy_t            vy,
    output logic [Y_W-1:0] y_next,
    output vy_t            vy_next,
    output logic           landed,
    output logic           bumped
);

    // One extra bit so y - vy can go negative or past the floor without wrapping.
    localparam int W  = Y_W + 1;
    localparam int VW = VY_W + 1;
    localparam logic signed [W-1:0]  FLOOR_S = W'(FLOOR_Y);
    localparam logic signed [VW-1:0] GRAV_S  = VW'(GRAVITY);
    localparam logic signed [VW-1:0] NEG_MAX = -VW'(MAX_FALL);

    logic signed [W-1:0]  y_s;
    logic signed [W-1:0]  vy_s;
    logic signed [W-1:0]  ny;
    logic signed [VW-1:0] vy_w;
    logic signed [VW-1:0] vy_dec;

    always_comb begin
        y_s    = {1'b0, y};
        vy_s   = {{(W - VY_W){vy[VY_W-1]}}, vy};
        ny     = y_s - vy_s;
        vy_w   = {vy[VY_W-1], vy};
        vy_dec = vy_w - GRAV_S;

        landed = (ny >= FLOOR_S);
        bumped = ny[W-1];

        y_next  = ny[Y_W-1:0];
        vy_next = (vy_dec < NEG_MAX) ? NEG_MAX[VY_W-1:0] : vy_dec[VY_W-1:0];

        if (landed) begin
            y_next  = FLOOR_S[Y_W-1:0];
            vy_next = '0;
        end else if (bumped) begin
            y_next  = '0;
            vy_next = '0;
        end
    end

endmodule

// File: rtl/kid_motion.sv
// rtl/kid_motion.sv - platformer sprite motion engine (run, double jump, gravity, death/respawn)
// Ports: clk        sole clock
//        rst        synchronous active-high reset, overrides update_en
//        bus.update_en  one-clock physics tick strobe; nothing moves without it
//        bus.keys       [0]=left [1]=right [2]=jump [3]=restart, active high
//        bus.hit        hazard contact, kills the sprite on a tick
//        bus.kid_x/kid_y    top-left corner of the sprite
//        bus.facing         1 = facing right
//        bus.kid_state      GROUND/JUMP/FALL/DEAD
//        bus.jumps_used     jumps consumed in the current airtime
//        bus.alive          0 while dead
// Build option: KID_WRAP_EN - horizontal motion wraps around the screen edges
//               instead of clamping.
module kid_motion
    import kid_pkg::*;
#(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int KID_W     = 16,
    parameter int KID_H     = 16,
    parameter int RUN_SPEED = 3,
    parameter int JUMP_VEL  = 8,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 9,
    parameter int MAX_JUMPS = 2,
    parameter int SPAWN_X   = 100,
    parameter int SPAWN_Y   = 464
) (
    input  logic         clk,
    input  logic         rst,
    kid_motion_if.slave  bus
);

    localparam int FLOOR_Y = SCREEN_H - KID_H;
    localparam int X_MAX   = SCREEN_W - KID_W;
    localparam int XW      = X_W + 1;
    localparam logic signed [XW-1:0] RUN_S   = XW'(RUN_SPEED);
    localparam logic signed [XW-1:0] X_MAX_S = XW'(X_MAX);
    localparam logic [X_W-1:0]       X_MAX_U = X_W'(X_MAX);
    localparam logic [1:0]           MAX_J   = 2'(MAX_JUMPS);
    localparam kid_state_t RESPAWN_ST = (SPAWN_Y == FLOOR_Y) ? ST_GROUND : ST_FALL;

    kid_state_t     state, state_n;
    logic [X_W-1:0] x, x_n;
    logic [Y_W-1:0] y, y_n;
    vy_t            vy, vy_n;
    logic           facing, facing_n;
    logic [1:0]     jumps, jumps_n;
    logic           prev_jump, prev_jump_n;

    logic [Y_W-1:0] step_y;
    vy_t            step_vy;
    logic           step_landed;
    logic           step_bumped;

    logic                 left_only;
    logic                 right_only;
    logic                 jump_edge;
    logic signed [XW-1:0] x_s;
    logic signed [XW-1:0] x_left;
    logic signed [XW-1:0] x_right;
    logic [X_W-1:0]       x_move;
    logic                 facing_move;

    kid_vert_step #(
        .Y_W      (Y_W),
        .FLOOR_Y  (FLOOR_Y),
        .GRAVITY  (GRAVITY),
        .MAX_FALL (MAX_FALL)
    ) u_vert (
        .y       (y),
        .vy      (vy),
        .y_next  (step_y),
        .vy_next (step_vy),
        .landed  (step_landed),
        .bumped  (step_bumped)
    );

    // Horizontal candidate position; applied only when the sprite is alive.
    always_comb begin
        left_only   = bus.keys[KEY_LEFT] & ~bus.keys[KEY_RIGHT];
        right_only  = bus.keys[KEY_RIGHT] & ~bus.keys[KEY_LEFT];
        x_s         = {1'b0, x};
        x_left      = x_s - RUN_S;
        x_right     = x_s + RUN_S;
        x_move      = x;
        facing_move = facing;
        if (left_only) begin
            facing_move = 1'b0;
            if (x_left[XW-1]) begin
`ifdef KID_WRAP_EN
                x_move = X_MAX_U;
`else
                x_move = '0;
`endif
            end else begin
                x_move = x_left[X_W-1:0];
            end
        end else if (right_only) begin
            facing_move = 1'b1;
            if (x_right > X_MAX_S) begin
`ifdef KID_WRAP_EN
                x_move = '0;
`else
                x_move = X_MAX_U;
`endif
            end else begin
                x_move = x_right[X_W-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_GROUND;
            x         <= X_W'(SPAWN_X);
            y         <= Y_W'(SPAWN_Y);
            vy        <= '0;
            facing    <= 1'b1;
            jumps     <= '0;
            prev_jump <= 1'b0;
        end else begin
            state     <= state_n;
            x         <= x_n;
            y         <= y_n;
            vy        <= vy_n;
            facing    <= facing_n;
            jumps     <= jumps_n;
            prev_jump <= prev_jump_n;
        end
    end

    // Next-state and datapath update for one tick.
    always_comb begin
        state_n     = state;
        x_n         = x;
        y_n         = y;
        vy_n        = vy;
        facing_n    = facing;
        jumps_n     = jumps;
        prev_jump_n = prev_jump;
        jump_edge   = bus.keys[KEY_JUMP] & ~prev_jump;

        if (bus.update_en) begin
            prev_jump_n = bus.keys[KEY_JUMP];
            if (bus.hit) begin
                // Death wins over everything else on the same tick.
                state_n = ST_DEAD;
                vy_n    = '0;
            end else if (state == ST_DEAD) begin
                if (bus.keys[KEY_RESTART]) begin
                    state_n  = RESPAWN_ST;
                    x_n      = X_W'(SPAWN_X);
                    y_n      = Y_W'(SPAWN_Y);
                    vy_n     = '0;
                    jumps_n  = '0;
                    facing_n = 1'b1;
                end
            end else begin
                x_n      = x_move;
                facing_n = facing_move;
                if (jump_edge && (jumps < MAX_J)) begin
                    // Launch tick: velocity loads, height stays put.
                    state_n = ST_JUMP;
                    vy_n    = VY_W'(JUMP_VEL);
                    jumps_n = jumps + 2'd1;
                end else if (state != ST_GROUND) begin
                    y_n  = step_y;
                    vy_n = step_vy;
                    if (step_landed) begin
                        state_n = ST_GROUND;
                        jumps_n = '0;
                    end else if (step_bumped) begin
                        state_n = ST_FALL;
                    end else begin
                        state_n = (!step_vy[VY_W-1] && (step_vy != '0)) ? ST_JUMP : ST_FALL;
                    end
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.kid_x      = x;
        bus.kid_y      = y;
        bus.facing     = facing;
        bus.kid_state  = state;
        bus.jumps_used = jumps;
        bus.alive      = (state != ST_DEAD);
    end

endmodule

// File: tb/tb_kid_motion.sv
// tb/tb_kid_motion.sv - self-checking bench for kid_motion with a behavioural reference model
module tb_kid_motion;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int KW    = 16;
    localparam int KH    = 16;
    localparam int FLOOR = SCR_H - KH;
    localparam int XMAX  = SCR_W - KW;
    localparam int RUN   = 3;
    localparam int JV    = 8;
    localparam int MAXF  = 9;
    localparam int MAXJ  = 2;
    localparam int SPX   = 100;
    localparam int SPY   = 464;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kid_motion_if #(.X_W(10), .Y_W(10)) bus ();

    kid_motion dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state, plain integers.
    int m_x, m_y, m_vy, m_state, m_jumps, m_facing, m_alive, m_prev;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = SPX; m_y = SPY; m_vy = 0; m_state = 0;
        m_jumps = 0; m_facing = 1; m_alive = 1; m_prev = 0;
    endtask

    task automatic model_step(input bit en, input logic [3:0] k, input bit h, input bit r);
        bit l, rt, jmp, edge_seen;
        int nx, ny;
        if (r) begin
            model_reset();
            return;
        end
        if (!en) return;
        l = k[0]; rt = k[1]; jmp = k[2];
        edge_seen = jmp && !m_prev;
        m_prev = jmp;
        if (h) begin
            m_state = 3; m_vy = 0; m_alive = 0;
        end else if (m_state == 3) begin
            if (k[3]) begin
                m_x = SPX; m_y = SPY; m_vy = 0; m_jumps = 0; m_facing = 1; m_alive = 1;
                m_state = (SPY == FLOOR) ? 0 : 2;
            end
        end else begin
            if (l && !rt) begin
                nx = m_x - RUN;
`ifdef KID_WRAP_EN
                if (nx < 0) nx = XMAX;
`else
                if (nx < 0) nx = 0;
`endif
                m_x = nx; m_facing = 0;
            end else if (rt && !l) begin
                nx = m_x + RUN;
`ifdef KID_WRAP_EN
                if (nx > XMAX) nx = 0;
`else
                if (nx > XMAX) nx = XMAX;
`endif
                m_x = nx; m_facing = 1;
            end
            if (edge_seen && m_jumps < MAXJ) begin
                m_vy = JV; m_jumps++; m_state = 1;
            end else if (m_state != 0) begin
                ny = m_y - m_vy;
                if (ny >= FLOOR) begin
                    m_y = FLOOR; m_vy = 0; m_jumps = 0; m_state = 0;
                end else if (ny < 0) begin
                    m_y = 0; m_vy = 0; m_state = 2;
                end else begin
                    m_y = ny;
                    m_vy = (m_vy - 1 < -MAXF) ? -MAXF : m_vy - 1;
                    m_state = (m_vy > 0) ? 1 : 2;
                end
            end
        end
    endtask

    task automatic tick(input bit en, input logic [3:0] k, input bit h, input bit r);
        @(negedge clk);
        bus.update_en = en;
        bus.keys      = k;
        bus.hit       = h;
        rst           = r;
        @(posedge clk);
        model_step(en, k, h, r);
        #1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("kid_x",      int'(bus.kid_x),      m_x);
            check("kid_y",      int'(bus.kid_y),      m_y);
            check("facing",     int'(bus.facing),     m_facing);
            check("kid_state",  int'(bus.kid_state),  m_state);
            check("jumps_used", int'(bus.jumps_used), m_jumps);
            check("alive",      int'(bus.alive),      m_alive);
        end
    end

    initial begin
        bus.update_en = 1'b0;
        bus.keys      = 4'd0;
        bus.hit       = 1'b0;
        model_reset();

        tick(0, 4'd0, 0, 1);
        chk_en = 1'b1;
        check("rst_x", int'(bus.kid_x), 100);
        check("rst_state", int'(bus.kid_state), 0);

        // Idle ticks after reset.
        for (int i = 0; i < 10; i++) tick(1, 4'd0, 0, 0);
        check("idle_x", int'(bus.kid_x), 100);
        check("idle_y", int'(bus.kid_y), 464);
        check("idle_state", int'(bus.kid_state), 0);
        check("idle_jumps", int'(bus.jumps_used), 0);
        check("idle_alive", int'(bus.alive), 1);

        // Single jump: apex then landing.
        tick(1, 4'b0100, 0, 0);
        check("jump_state", int'(bus.kid_state), 1);
        check("jump_y", int'(bus.kid_y), 464);
        for (int i = 0; i < 8; i++) tick(1, 4'd0, 0, 0);
        check("apex_y", int'(bus.kid_y), 428);
        check("apex_state", int'(bus.kid_state), 2);
        for (int i = 0; i < 9; i++) tick(1, 4'd0, 0, 0);
        check("land_y", int'(bus.kid_y), 464);
        check("land_state", int'(bus.kid_state), 0);
        check("land_jumps", int'(bus.jumps_used), 0);

        // Double jump at apex, third press ignored.
        tick(1, 4'b0100, 0, 0);
        for (int i = 0; i < 8; i++) tick(1, 4'd0, 0, 0);
        tick(1, 4'b0100, 0, 0);
        check("dj_jumps", int'(bus.jumps_used), 2);
        check("dj_y", int'(bus.kid_y), 428);
        tick(1, 4'd0, 0, 0);
        tick(1, 4'b0100, 0, 0);
        check("tj_jumps", int'(bus.jumps_used), 2);
        check("tj_y", int'(bus.kid_y), 413);
        for (int i = 0; i < 40; i++) tick(1, 4'd0, 0, 0);
        check("dj_land_state", int'(bus.kid_state), 0);

        // Left edge.
        for (int i = 0; i < 33; i++) tick(1, 4'b0001, 0, 0);
        check("edge_x1", int'(bus.kid_x), 1);
        check("edge_facing", int'(bus.facing), 0);
        tick(1, 4'b0001, 0, 0);
`ifdef KID_WRAP_EN
        check("edge_x_wrap", int'(bus.kid_x), 624);
`else
        check("edge_x_clamp", int'(bus.kid_x), 0);
`endif
        tick(1, 4'b0011, 0, 0);
`ifdef KID_WRAP_EN
        check("both_x", int'(bus.kid_x), 624);
`else
        check("both_x", int'(bus.kid_x), 0);
`endif

        // Hit with jump edge, then respawn.
        tick(1, 4'b0100, 1, 0);
        check("dead_state", int'(bus.kid_state), 3);
        check("dead_alive", int'(bus.alive), 0);
        check("dead_y", int'(bus.kid_y), 464);
        check("dead_jumps", int'(bus.jumps_used), 0);
        tick(1, 4'b0010, 0, 0);
        check("dead_state2", int'(bus.kid_state), 3);
        tick(1, 4'b1000, 0, 0);
        check("resp_x", int'(bus.kid_x), 100);
        check("resp_y", int'(bus.kid_y), 464);
        check("resp_alive", int'(bus.alive), 1);
        check("resp_facing", int'(bus.facing), 1);

        // Reset mid-jump with update_en low.
        tick(1, 4'b0110, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 4'b0010, 0, 0);
        tick(0, 4'd0, 0, 1);
        check("mrst_x", int'(bus.kid_x), 100);
        check("mrst_y", int'(bus.kid_y), 464);
        check("mrst_state", int'(bus.kid_state), 0);
        check("mrst_jumps", int'(bus.jumps_used), 0);
        tick(1, 4'd0, 0, 0);
        check("mrst_still_y", int'(bus.kid_y), 464);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            bit en, h, r;
            logic [3:0] k;
            en = ($urandom_range(0, 3) != 0);
            k  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) k[3] = 1'b0;
            h  = ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 499) == 0);
            tick(en, k, h, r);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
